sprot_tx: RTL

Transmitter/initiator for the simple start/a/b protocol: drives `start`, then `a`, then `b` on three consecutive cycles for each accepted request. It then waits for the far end's `xfer_end`/`prot_err` response and reports completion status. It sits in front of the sprot receiver, or drives the DUT pins in a bench harness. It supports deliberate protocol-violation injection so the receiver's error path can be exercised.

---
 rtl/sprot_pkg.sv | 22 ++
 rtl/sprot_tx_if.sv | 27 ++
 rtl/sprot_rsp_timer.sv | 27 ++
 rtl/sprot_tx.sv | 118 +++++++++++
 4 files changed

// File: rtl/sprot_pkg.sv
// Shared types for the start/a/b protocol: fault-injection modes, transmitter
// states, the completion record, and helpers for deciding which phases to drop.
package sprot_pkg;
  typedef enum bit [1:0] {NORMAL = 2'd0, DROP_A = 2'd1, DROP_B = 2'd2, DROP_AB = 2'd3} sprot_err_mode_t;
  typedef enum bit [2:0] {TX_IDLE, TX_START, TX_A, TX_B, TX_WAIT, TX_GAP} sprot_tx_fsm_t;

  typedef struct packed {
    logic done;
    logic err;
    logic timeout;
  } sprot_rsp_t;

  localparam int TMR_W = 8;

  function automatic logic drop_a(sprot_err_mode_t m);
    return (m == DROP_A) || (m == DROP_AB);
  endfunction

  function automatic logic drop_b(sprot_err_mode_t m);
    return (m == DROP_B) || (m == DROP_AB);
  endfunction
endpackage

// File: rtl/sprot_tx_if.sv
// Request / protocol / completion bundle of the sprot transmitter.
// master = transmitter side, slave = requester and far-end responder.
interface sprot_tx_if #(parameter int CNT_W = 16);
  logic                      req_valid;
  logic                      req_ready;
  sprot_pkg::sprot_err_mode_t req_mode;
  logic                      start;
  logic                      a;
  logic                      b;
  logic                      xfer_end;
  logic                      prot_err;
  logic                      done;
  logic                      done_err;
  logic                      done_timeout;
  logic                      busy;
  logic [CNT_W-1:0]          xfer_cnt;
  logic [CNT_W-1:0]          err_cnt;

  modport master (
    input  req_valid, req_mode, xfer_end, prot_err,
    output req_ready, start, a, b, done, done_err, done_timeout, busy, xfer_cnt, err_cnt
  );
  modport slave (
    output req_valid, req_mode, xfer_end, prot_err,
    input  req_ready, start, a, b, done, done_err, done_timeout, busy, xfer_cnt, err_cnt
  );
endinterface

// File: rtl/sprot_rsp_timer.sv
// Loadable down-counter shared by the response timeout and the post-completion gap.
// expire is high while the count sits at zero.
module sprot_rsp_timer import sprot_pkg::*; #(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/sprot_tx.sv
// sprot initiator: emits start/a/b on three consecutive cycles per request,
// waits for xfer_end or a timeout, then reports status and holds off for a gap.
module sprot_tx import sprot_pkg::*; #(
  parameter int RSP_TIMEOUT = 8,
  parameter int MIN_GAP     = 2,
  parameter int CNT_W       = 16
) (
  input logic        clk,
  input logic        rst_n,
  sprot_tx_if.master bus
);
  sprot_tx_fsm_t   state_q, state_d;
  sprot_err_mode_t mode_q, mode_d;
  logic            start_q, start_d, a_q, a_d, b_q, b_d;
  sprot_rsp_t      rsp_q, rsp_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d, err_cnt_q, err_cnt_d;
  logic             tmr_load, tmr_dec, tmr_exp;
  logic [TMR_W-1:0] tmr_val;

  sprot_rsp_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    start_d    = 1'b0;
    a_d        = 1'b0;
    b_d        = 1'b0;
    rsp_d      = '0;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    case (state_q)
      TX_IDLE: if (bus.req_valid) begin
        mode_d  = bus.req_mode;
        start_d = 1'b1;
        state_d = TX_START;
      end
      TX_START: begin
        a_d     = !drop_a(mode_q);
        state_d = TX_A;
      end
      TX_A: begin
        b_d     = !drop_b(mode_q);
        state_d = TX_B;
      end
      TX_B: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(RSP_TIMEOUT - 1);
        state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        tmr_dec = 1'b1;
        // xfer_end takes priority over a coincident timeout
        if (bus.xfer_end || tmr_exp) begin
          rsp_d.done    = 1'b1;
          rsp_d.err     = bus.xfer_end & bus.prot_err;
          rsp_d.timeout = !bus.xfer_end;
          xfer_cnt_d    = xfer_cnt_q + 1'b1;
          if (rsp_d.err || rsp_d.timeout) err_cnt_d = err_cnt_q + 1'b1;
          if (MIN_GAP == 0) state_d = TX_IDLE;
          else begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(MIN_GAP - 1);
            state_d  = TX_GAP;
          end
        end
      end
      TX_GAP: begin
        tmr_dec = 1'b1;
        if (tmr_exp) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      mode_q     <= NORMAL;
      start_q    <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      rsp_q      <= '0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_q      <= rsp_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // gated by rst_n so the handshake stays closed while reset is held
  assign bus.req_ready    = rst_n & (state_q == TX_IDLE);
  assign bus.busy         = (state_q != TX_IDLE);
  assign bus.start        = start_q;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.done         = rsp_q.done;
  assign bus.done_err     = rsp_q.err;
  assign bus.done_timeout = rsp_q.timeout;
  assign bus.xfer_cnt     = xfer_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
endmodule
